// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared encodings for the ALU control sequencer:
//   - ALUOp field encodings (load/store, branch, R-format, I-format)
//   - opcode / funct constants for the legal decode tuples
//   - 4-bit ALU control codes (zero-extended to CTRL_W by the decoder)
//   - FSM state encoding (state_t), also exposed on the debug port
// Optional feature macro: ALU_CTRL_MUL_EN (multi-cycle MUL decode).
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  // ALUOp encodings
  localparam logic [1:0] ALU_OP_LS = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;
  localparam logic [1:0] ALU_OP_R  = 2'b10;
  localparam logic [1:0] ALU_OP_I  = 2'b11;

  // R-format opcodes (low four bits)
  localparam logic [3:0] OPC_LOGIC = 4'b0000;
  localparam logic [3:0] OPC_ARITH = 4'b0001;
  localparam logic [3:0] OPC_SHIFT = 4'b0010;
  localparam logic [3:0] OPC_MUL   = 4'b0011;

  // I-format opcodes (low four bits)
  localparam logic [3:0] OPC_ADDI = 4'b1001;
  localparam logic [3:0] OPC_SUBI = 4'b1010;
  localparam logic [3:0] OPC_SLTI = 4'b1011;

  // R-format funct values (low two bits)
  localparam logic [1:0] FN_0 = 2'b00;
  localparam logic [1:0] FN_1 = 2'b01;
  localparam logic [1:0] FN_2 = 2'b10;

  // ALU control codes
  localparam logic [3:0] CTRL_NONE = 4'b0000;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_ADD  = 4'b0100;
  localparam logic [3:0] CTRL_SUB  = 4'b1100;
  localparam logic [3:0] CTRL_SLL  = 4'b0110;
  localparam logic [3:0] CTRL_SRA  = 4'b0111;
  localparam logic [3:0] CTRL_SLT  = 4'b0001;
  localparam logic [3:0] CTRL_MUL  = 4'b1000;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq_if
// Request/result bundle of the ALU control sequencer.
//   request : in_valid, in_ready, alu_op, opcode, funct
//   result  : out_valid, out_ready, alu_ctrl, illegal
//   status  : busy
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. A source keeps valid and its payload
// stable until that edge; ready may depend combinationally on the sink's
// state and on the downstream ready, never on the source's valid.
// Modports: master = request producer / result consumer, slave = sequencer.
// -----------------------------------------------------------------------------
interface alu_ctrl_seq_if #(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 2,
  parameter int CTRL_W  = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, alu_op, opcode, funct, out_ready,
    input  in_ready, out_valid, alu_ctrl, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, opcode, funct, out_ready,
    output in_ready, out_valid, alu_ctrl, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decode of an (alu_op, opcode, funct) tuple.
// Ports:
//   alu_op   in  2        ALUOp class
//   opcode   in  OP_W     instruction opcode (bits above 3 must be zero)
//   funct    in  FUNCT_W  R-format funct (bits above 1 must be zero)
//   code     out CTRL_W   ALU control code, zero-extended; 0 when illegal
//   illegal  out 1        tuple matches no legal encoding
//   is_multi out 1        tuple is the multi-cycle MUL
// Optional feature macro: ALU_CTRL_MUL_EN (adds MUL decode).
// -----------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 2,
  parameter int CTRL_W  = 4
) (
  input  logic [1:0]         alu_op,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  code,
  output logic               illegal,
  output logic               is_multi
);

  logic       op_hi_zero;
  logic       fn_hi_zero;
  logic [3:0] opc4;
  logic [1:0] fn2;
  logic [3:0] code4;
  logic       hit;

  // Shifts avoid empty slices when the widths sit at their minimum.
  assign op_hi_zero = ((opcode >> 4) == '0);
  assign fn_hi_zero = ((funct >> 2) == '0);
  assign opc4       = opcode[3:0];
  assign fn2        = funct[1:0];

  always_comb begin
    code4    = CTRL_NONE;
    hit      = 1'b0;
    is_multi = 1'b0;
    case (alu_op)
      ALU_OP_LS: begin
        code4 = CTRL_ADD;
        hit   = 1'b1;
      end
      ALU_OP_BR: begin
        code4 = CTRL_SUB;
        hit   = 1'b1;
      end
      ALU_OP_R: begin
        if (op_hi_zero && fn_hi_zero) begin
          hit = 1'b1;
          case ({opc4, fn2})
            {OPC_LOGIC, FN_0}: code4 = CTRL_AND;
            {OPC_LOGIC, FN_1}: code4 = CTRL_OR;
            {OPC_LOGIC, FN_2}: code4 = CTRL_XOR;
            {OPC_ARITH, FN_0}: code4 = CTRL_ADD;
            {OPC_ARITH, FN_1}: code4 = CTRL_SUB;
            {OPC_SHIFT, FN_0}: code4 = CTRL_SLL;
            {OPC_SHIFT, FN_1}: code4 = CTRL_SRA;
`ifdef ALU_CTRL_MUL_EN
            {OPC_MUL, FN_0}: begin
              code4    = CTRL_MUL;
              is_multi = 1'b1;
            end
`endif
            default: hit = 1'b0;
          endcase
        end
      end
      default: begin // ALU_OP_I: funct is don't-care
        if (op_hi_zero) begin
          hit = 1'b1;
          case (opc4)
            OPC_ADDI: code4 = CTRL_ADD;
            OPC_SUBI: code4 = CTRL_SUB;
            OPC_SLTI: code4 = CTRL_SLT;
            default:  hit   = 1'b0;
          endcase
        end
      end
    endcase
  end

  // A miss always drives zero, so nothing stale can leak through.
  assign code    = hit ? CTRL_W'(code4) : '0;
  assign illegal = ~hit;

endmodule

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
// Registered ALU control decoder with a valid/ready request and result
// channel. Single-cycle ops produce a result one cycle after acceptance and
// can stream back-to-back; the optional MUL holds the block busy for
// MUL_LAT-1 cycles and presents its result MUL_LAT cycles after acceptance.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   bus        slave modport of alu_ctrl_seq_if (request/result/busy)
//   dbg_state  out  current FSM state
// Optional feature macro: ALU_CTRL_MUL_EN (MUL decode, MULTI state, counter).
// -----------------------------------------------------------------------------
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 2,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_ctrl_seq_if.slave  bus,
  output state_t         dbg_state
);

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              illegal_q, illegal_d;
  logic              in_ready;
  logic              accept;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_is_multi;

`ifdef ALU_CTRL_MUL_EN
  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
`else
  logic mul_unused;
  assign mul_unused = dec_is_multi | (MUL_LAT < 2);
`endif

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNCT_W(FUNCT_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op  (bus.alu_op),
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .code    (dec_code),
    .illegal (dec_illegal),
    .is_multi(dec_is_multi)
  );

  // Ready in VALID only when the pending result leaves on the same edge.
  assign in_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_VALID) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    illegal_d   = illegal_q;
`ifdef ALU_CTRL_MUL_EN
    cnt_d       = cnt_q;
    busy_d      = busy_q;
`endif
    case (state_q)
      ST_IDLE, ST_VALID: begin
        if (accept) begin
          alu_ctrl_d  = dec_code;
          illegal_d   = dec_illegal;
          state_d     = ST_VALID;
          out_valid_d = 1'b1;
`ifdef ALU_CTRL_MUL_EN
          if (dec_is_multi) begin
            state_d     = ST_MULTI;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
            cnt_d       = CNT_LOAD;
          end
`endif
        end else if ((state_q == ST_VALID) && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef ALU_CTRL_MUL_EN
      ST_MULTI: begin
        if (cnt_q == '0) begin
          state_d     = ST_VALID;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      cnt_q       <= '0;
      busy_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      illegal_q   <= illegal_d;
`ifdef ALU_CTRL_MUL_EN
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.illegal   = illegal_q;
`ifdef ALU_CTRL_MUL_EN
  assign bus.busy      = busy_q;
`else
  assign bus.busy      = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule
